multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters, one per line:
  - BYTE_EN, default 1, enables LDRB/STRB byte-lane decode; when 0, be is always 4'b1111.
  - MEM_WAIT_MAX, default 15, maximum memory-wait cycles before fault.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 Ports, one per line:
  - clk  in  1  rising-edge clock
  - reset  in  1  synchronous, active-low reset
  - Instr  in  27  instruction bits [31:5], valid while IR holds the instruction
  - ALUFlags  in  4  N,Z,C,V from ALU
  - mem_ready  in  1  memory completed current access
  - mem_req  out  1  memory access request
  - PCWrite  out  1  PC update enable
  - AdrSrc  out  1  0=PC, 1=ALU result as address
  - IRWrite  out  1  instruction register load
  - RegWrite  out  1  register file write (condition-gated)
  - MemWrite  out  1  data store strobe (condition-gated)
  - ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU direct
  - ALUSrcA  out  1  0=Rn, 1=PC
  - ALUSrcB  out  2  00=Rm/shifted, 01=ExtImm, 10=constant 4
  - ImmSrc  out  2  immediate format
  - RegSrc  out  2  register-address muxing
  - ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
  - be  out  4  byte enables
  - fault  out  1  sticky memory-timeout flag

Function
REQ-004 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT.
REQ-005 FETCH: assert mem_req, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. On mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay in FETCH.
REQ-006 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 read). Next state from Instr[27:26]:
  - 01 -> MEMADR
  - 10 -> BRANCH
  - 00 with Instr[25]=1 -> EXECI
  - 00 with Instr[25]=0 -> EXECR
  - 11 -> FETCH (undefined opcode, no side effects)
REQ-007 MEMADR: ALUSrcB=01, ALUControl=00 if U bit Instr[23]=1, else 01. Then go to MEMRD if L bit Instr[20]=1, else MEMWR.
REQ-008 MEMRD: mem_req=1, AdrSrc=1; on mem_ready go to MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx; then FETCH.
REQ-009 MEMWR: mem_req=1, AdrSrc=1, MemWrite=CondEx, held until mem_ready; then FETCH.
REQ-010 EXECR/EXECI: ALUSrcB=00 or 01 respectively. ALUControl decoded from cmd Instr[24:21]:
  - 0100 ADD -> 00
  - 0010 SUB -> 01
  - 0000 AND -> 10
  - 1100 ORR -> 11
  - 1010 CMP -> 01, no writeback
  Flags update when S bit Instr[20]=1 and CondEx. Then ALUWB, except CMP which goes to FETCH.
REQ-011 ALUWB: ResultSrc=00, RegWrite=CondEx; then FETCH.
REQ-012 BRANCH: ALUSrcA=1, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx; then FETCH.
REQ-013 CondEx is decoded from Instr[31:28] against the registered NZCV flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code 1111 gives CondEx=0.
REQ-014 Flag register write is split in two groups:
  - N,Z load on FlagW[1]
  - C,V load on FlagW[0]
  - FlagW=2'b11 for SUB/CMP, and 2'b10 for AND/ORR, when S=1.
  The new flags take effect from the next instruction.
REQ-015 be depends on BYTE_EN and the byte bit Instr[22]:
  - BYTE_EN=1 and Instr[22]=1 in MEMRD/MEMWR: be is one-hot by ALU address bits [1:0] (00->0001 ... 11->1000).
  - Otherwise be=4'b1111.
REQ-016 Wait counter: clears on entry to any mem_req state and increments each cycle mem_ready=0. When it reaches MEM_WAIT_MAX with mem_ready still low, go to FAULT.
REQ-017 FAULT is terminal until reset: fault=1, all strobes and enables 0.
REQ-018 Strobes (PCWrite, IRWrite, RegWrite, MemWrite, mem_req) are high only in the states listed above; they are 0 in all others.
REQ-019 mem_ready is ignored in states with mem_req=0.

Reset
REQ-020 reset=0 sampled at a clock edge forces:
  - state=FETCH, NZCV=0000, wait counter=0, fault=0
  - all strobes 0 during the reset cycle
REQ-021 Reset mid-access aborts the access; no MemWrite or RegWrite is issued after reset is asserted.

Verification
REQ-022 ADD R1,R2,R3 (cond AL, S=0), mem_ready=1 always -> FETCH, DECODE, EXECR, ALUWB, 4 cycles; RegWrite=1 only in ALUWB; ALUControl=00.
REQ-023 SUBS then BEQ, with equal operands -> Z=1 latched. Branch: PCWrite=1 in BRANCH. Repeat with unequal operands -> PCWrite=0 in BRANCH.
REQ-024 STRB, BYTE_EN=1, address[1:0]=10, mem_ready delayed 3 cycles -> MEMWR held 4 cycles; MemWrite=1, be=0100 throughout.
REQ-025 LDR with mem_ready low for MEM_WAIT_MAX+1 cycles -> FAULT entered; fault=1, strobes 0. Then reset=0 for one cycle -> FETCH, fault=0.
REQ-026 reset=0 asserted during MEMWR -> next cycle state=FETCH, MemWrite=0, NZCV=0000.
REQ-027 CMP with cond NE while Z=1 -> no flag change; returns to FETCH after EXECR; RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: instruction sequencing FSM, condition check against a
// split NZCV flag register, byte-lane enables and a memory-wait watchdog that parks in FAULT.
module multicycle_controller #(
    parameter bit BYTE_EN      = 1'b1,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:5] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  ALUAddr,    // low bits of the ALU-computed data address
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  be,
    output logic        fault
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT
    } state_t;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam int CW = $clog2(MEM_WAIT_MAX + 2);

    state_t        state, state_next;
    logic [3:0]    nzcv;
    logic [CW-1:0] wait_cnt;
    logic          cond_ex, cond_q;
    logic [1:0]    flag_w, flag_grp, alu_dec;
    logic          is_cmp, be_sel, timeout;

    logic [1:0] op;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign unused_instr = ^Instr[19:5];
    assign ImmSrc       = op;
    assign RegSrc       = {(op == 2'b01) && !Instr[20], op == 2'b10};
    assign fault        = (state == FAULT);
    assign timeout      = !mem_ready && (wait_cnt == CW'(MEM_WAIT_MAX));

    always_comb begin
        case (cond_t'(Instr[31:28]))
            EQ: cond_ex = nzcv[2];
            NE: cond_ex = !nzcv[2];
            CS: cond_ex = nzcv[1];
            CC: cond_ex = !nzcv[1];
            MI: cond_ex = nzcv[3];
            PL: cond_ex = !nzcv[3];
            VS: cond_ex = nzcv[0];
            VC: cond_ex = !nzcv[0];
            HI: cond_ex = nzcv[1] && !nzcv[2];
            LS: cond_ex = !nzcv[1] || nzcv[2];
            GE: cond_ex = (nzcv[3] == nzcv[0]);
            LT: cond_ex = (nzcv[3] != nzcv[0]);
            GT: cond_ex = !nzcv[2] && (nzcv[3] == nzcv[0]);
            LE: cond_ex = nzcv[2] || (nzcv[3] != nzcv[0]);
            AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // flag_grp: which flag groups the command may load ({N,Z}, {C,V})
    always_comb begin
        alu_dec  = 2'b00;
        flag_grp = 2'b00;
        is_cmp   = 1'b0;
        case (Instr[24:21])
            CMD_ADD: begin alu_dec = 2'b00; flag_grp = 2'b11; end
            CMD_SUB: begin alu_dec = 2'b01; flag_grp = 2'b11; end
            CMD_AND: begin alu_dec = 2'b10; flag_grp = 2'b10; end
            CMD_ORR: begin alu_dec = 2'b11; flag_grp = 2'b10; end
            CMD_CMP: begin alu_dec = 2'b01; flag_grp = 2'b11; is_cmp = 1'b1; end
            default: ;
        endcase
    end

    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        flag_w     = 2'b00;
        be_sel     = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    2'b00:   state_next = Instr[25] ? EXECI : EXECR;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = Instr[23] ? 2'b00 : 2'b01;
                state_next = Instr[20] ? MEMRD : MEMWR;
            end
            MEMRD, MEMWR: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                be_sel   = 1'b1;
                MemWrite = (state == MEMWR) && cond_q;
                if (mem_ready)    state_next = (state == MEMRD) ? MEMWB : FETCH;
                else if (timeout) state_next = FAULT;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = cond_q;
                state_next = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                flag_w     = (Instr[20] && cond_q) ? flag_grp : 2'b00;
                state_next = is_cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                RegWrite   = cond_q;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = cond_q;
                state_next = FETCH;
            end
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase

        // An asserted reset kills any in-flight access in the same cycle.
        if (!reset) begin
            mem_req  = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end

        be = 4'b1111;
        if (state == FAULT)                     be = 4'b0000;
        else if (be_sel && BYTE_EN && Instr[22]) be = 4'b0001 << ALUAddr;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            nzcv     <= 4'b0000;
            wait_cnt <= '0;
            cond_q   <= 1'b0;
        end else begin
            state <= state_next;
            // Condition is frozen at decode so this instruction's own flag write can't affect it.
            if (state == DECODE) cond_q     <= cond_ex;
            if (flag_w[1])       nzcv[3:2]  <= ALUFlags[3:2];
            if (flag_w[0])       nzcv[1:0]  <= ALUFlags[1:0];
            if (state_next != state)         wait_cnt <= '0;
            else if (mem_req && !mem_ready)  wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule
